// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the CPU/DMA memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DFLT     = 32;
  localparam int unsigned DATA_W_DFLT     = 16;
  localparam int unsigned WBUF_DEPTH_DFLT = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/mem_wbuf.sv
// Posted-write FIFO of {addr,data}; a push while full is accepted only
// when a pop frees a slot on the same edge.
module mem_wbuf #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [AW-1:0]            head_addr,
  output logic [DW-1:0]            head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '{default: '0};
      data_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU (blocking reads, posted writes)
// and a DMA master (full handshake), round-robin on ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned N          = ADDR_W_DFLT,
  parameter int unsigned M          = DATA_W_DFLT,
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DFLT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 cpuAddr,
  input  logic [M-1:0]                 cpuWrite,
  input  logic                         cpuRE,
  input  logic                         cpuWE,
  output logic [M-1:0]                 cpuRead,
  output logic                         cpuReady,
  input  logic [N-1:0]                 dmaAddr,
  input  logic [M-1:0]                 dmaWrite,
  input  logic                         dmaRE,
  input  logic                         dmaWE,
  output logic [M-1:0]                 dmaRead,
  output logic                         dmaReady,
  output logic [N-1:0]                 memAddr,
  output logic [M-1:0]                 memWrite,
  output logic                         memRE,
  output logic                         memWE,
  input  logic [M-1:0]                 memRead,
  input  logic                         memReady,
  output logic [$clog2(WBUF_DEPTH):0]  wbufCount,
  output logic                         wbufOverflow
);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  op_e           op_q, op_d;
  logic [N-1:0]  addr_q, addr_d;
  logic [M-1:0]  wdata_q, wdata_d;
  logic [M-1:0]  rdata_q, rdata_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          dma_ready_q, dma_ready_d;
  logic          ovf_q, ovf_d;

  logic          wb_pop;
  logic          wb_full;
  logic          wb_empty;
  logic [N-1:0]  wb_head_addr;
  logic [M-1:0]  wb_head_data;
  logic          cpu_cand;
  logic          dma_cand;

  mem_wbuf #(
    .AW    (N),
    .DW    (M),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (cpuWE),
    .push_addr (cpuAddr),
    .push_data (cpuWrite),
    .pop       (wb_pop),
    .head_addr (wb_head_addr),
    .head_data (wb_head_data),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wbufCount)
  );

  // A same-cycle cpuWE keeps the read behind the write it may depend on.
  assign cpu_cand = !wb_empty || (cpuRE && !cpuWE);
  assign dma_cand = dmaRE || dmaWE;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    cpu_ready_d = 1'b0;
    dma_ready_d = 1'b0;
    wb_pop      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (cpu_cand && (!dma_cand || owner_q == OWN_DMA)) begin
          owner_d = OWN_CPU;
          state_d = ARB_BUSY;
          if (!wb_empty) begin
            op_d     = OP_WRITE;
            addr_d   = wb_head_addr;
            wdata_d  = wb_head_data;
            mem_we_d = 1'b1;
            wb_pop   = 1'b1;
          end else begin
            op_d     = OP_READ;
            addr_d   = cpuAddr;
            mem_re_d = 1'b1;
          end
        end else if (dma_cand) begin
          owner_d = OWN_DMA;
          state_d = ARB_BUSY;
          addr_d  = dmaAddr;
          if (dmaWE) begin
            op_d     = OP_WRITE;
            wdata_d  = dmaWrite;
            mem_we_d = 1'b1;
          end else begin
            op_d     = OP_READ;
            mem_re_d = 1'b1;
          end
        end
      end
      ARB_BUSY: begin
        if (memReady) begin
          rdata_d     = memRead;
          mem_re_d    = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = ARB_DONE;
          cpu_ready_d = (owner_q == OWN_CPU) && (op_q == OP_READ);
          dma_ready_d = (owner_q == OWN_DMA);
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    ovf_d = ovf_q || (cpuWE && wb_full && !wb_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_DMA;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      cpu_ready_q <= cpu_ready_d;
      dma_ready_q <= dma_ready_d;
      ovf_q       <= ovf_d;
    end
  end

  assign memAddr      = addr_q;
  assign memWrite     = wdata_q;
  assign memRE        = mem_re_q;
  assign memWE        = mem_we_q;
  assign cpuRead      = rdata_q;
  assign dmaRead      = rdata_q;
  assign cpuReady     = cpu_ready_q;
  assign dmaReady     = dma_ready_q;
  assign wbufOverflow = ovf_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory accesses
// and ready pulses; a negedge monitor pops and compares them as they appear.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpuAddr, dmaAddr, memAddr;
  logic [15:0] cpuWrite, dmaWrite, memWrite, memRead, cpuRead, dmaRead;
  logic        cpuRE, cpuWE, dmaRE, dmaWE, memRE, memWE, memReady;
  logic        cpuReady, dmaReady, wbufOverflow;
  logic [1:0]  wbufCount;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpuAddr(cpuAddr), .cpuWrite(cpuWrite), .cpuRE(cpuRE), .cpuWE(cpuWE),
    .cpuRead(cpuRead), .cpuReady(cpuReady),
    .dmaAddr(dmaAddr), .dmaWrite(dmaWrite), .dmaRE(dmaRE), .dmaWE(dmaWE),
    .dmaRead(dmaRead), .dmaReady(dmaReady),
    .memAddr(memAddr), .memWrite(memWrite), .memRE(memRE), .memWE(memWE),
    .memRead(memRead), .memReady(memReady),
    .wbufCount(wbufCount), .wbufOverflow(wbufOverflow)
  );

  always #5 clk = ~clk;

  typedef struct { bit we; logic [31:0] addr; logic [15:0] data; int cyc; } acc_t;
  typedef struct { logic [15:0] data; bit chk; int cyc; } rsp_t;

  acc_t exp_mem[$];
  rsp_t exp_cpu[$];
  rsp_t exp_dma[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  bit acc_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: memReady after mem_lat low cycles; read data = addr[15:0] ^ 0xACDB.
  always @(negedge clk) begin
    if ((memRE || memWE) && !rst) begin
      if (wait_cnt < mem_lat) begin
        memReady = 1'b0;
        wait_cnt++;
      end else begin
        memReady = 1'b1;
        memRead  = memAddr[15:0] ^ 16'hACDB;
        wait_cnt = 0;
      end
    end else begin
      memReady = 1'b0;
      memRead  = '0;
      wait_cnt = 0;
    end
  end

  // Monitor: compares each new memory access and each ready pulse against the queues.
  always @(negedge clk) begin
    acc_t e;
    rsp_t r;
    if (!rst) begin
      if ((memRE || memWE) && !acc_prev) begin
        n_vec++;
        if (exp_mem.size() == 0) begin
          n_err++;
          $display("FAIL mem_access: got unexpected re=%0b we=%0b addr=%h data=%h at cyc %0d, required none",
                   memRE, memWE, memAddr, memWrite, cyc);
        end else begin
          e = exp_mem.pop_front();
          if (memWE !== e.we || memRE !== !e.we || memAddr !== e.addr ||
              (e.we && memWrite !== e.data) || (e.cyc >= 0 && cyc != e.cyc)) begin
            n_err++;
            $display("FAIL mem_access: got we=%0b re=%0b addr=%h data=%h cyc %0d, required we=%0b addr=%h data=%h cyc %0d",
                     memWE, memRE, memAddr, memWrite, cyc, e.we, e.addr, e.data, e.cyc);
          end
        end
      end
      if (cpuReady) begin
        n_vec++;
        if (exp_cpu.size() == 0) begin
          n_err++;
          $display("FAIL cpu_ready: got unexpected pulse data=%h at cyc %0d, required none", cpuRead, cyc);
        end else begin
          r = exp_cpu.pop_front();
          if (cpuRead !== r.data || (r.cyc >= 0 && cyc != r.cyc)) begin
            n_err++;
            $display("FAIL cpu_ready: got data=%h cyc %0d, required data=%h cyc %0d", cpuRead, cyc, r.data, r.cyc);
          end
        end
      end
      if (dmaReady) begin
        n_vec++;
        if (exp_dma.size() == 0) begin
          n_err++;
          $display("FAIL dma_ready: got unexpected pulse data=%h at cyc %0d, required none", dmaRead, cyc);
        end else begin
          r = exp_dma.pop_front();
          if ((r.chk && dmaRead !== r.data) || (r.cyc >= 0 && cyc != r.cyc)) begin
            n_err++;
            $display("FAIL dma_ready: got data=%h cyc %0d, required data=%h cyc %0d", dmaRead, cyc, r.data, r.cyc);
          end
        end
      end
    end
    acc_prev = memRE || memWE;
  end

  function automatic void exp_acc(bit we, logic [31:0] a, logic [15:0] d, int c);
    acc_t e;
    e.we = we; e.addr = a; e.data = d; e.cyc = c;
    exp_mem.push_back(e);
  endfunction

  function automatic void exp_rsp(bit is_cpu, logic [15:0] d, bit chk, int c);
    rsp_t r;
    r.data = d; r.chk = chk; r.cyc = c;
    if (is_cpu) exp_cpu.push_back(r);
    else        exp_dma.push_back(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic settle(input int n, input string name);
    repeat (n) tick();
    n_vec++;
    if (exp_mem.size() != 0 || exp_cpu.size() != 0 || exp_dma.size() != 0) begin
      n_err++;
      $display("FAIL %s drained: got pending mem=%0d cpu=%0d dma=%0d, required 0/0/0",
               name, exp_mem.size(), exp_cpu.size(), exp_dma.size());
    end
    exp_mem.delete();
    exp_cpu.delete();
    exp_dma.delete();
  endtask

  task automatic wait_cpu_ready(input string name);
    int i = 0;
    while (!cpuReady && i < 200) begin tick(); i++; end
    if (!cpuReady) begin
      n_vec++; n_err++;
      $display("FAIL %s: got no cpuReady within 200 cycles, required a pulse", name);
    end
    cpuRE = 1'b0;
  endtask

  task automatic wait_dma_ready(input string name);
    int i = 0;
    while (!dmaReady && i < 200) begin tick(); i++; end
    if (!dmaReady) begin
      n_vec++; n_err++;
      $display("FAIL %s: got no dmaReady within 200 cycles, required a pulse", name);
    end
    dmaRE = 1'b0;
    dmaWE = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1;
    cpuAddr = '0; cpuWrite = '0; cpuRE = 1'b0; cpuWE = 1'b0;
    dmaAddr = '0; dmaWrite = '0; dmaRE = 1'b0; dmaWE = 1'b0;
    memReady = 1'b0; memRead = '0;
    repeat (3) tick();

    check("rst memRE", 32'(memRE), 32'd0);
    check("rst memWE", 32'(memWE), 32'd0);
    check("rst memAddr", memAddr, 32'd0);
    check("rst memWrite", 32'(memWrite), 32'd0);
    check("rst cpuRead", 32'(cpuRead), 32'd0);
    check("rst cpuReady", 32'(cpuReady), 32'd0);
    check("rst dmaRead", 32'(dmaRead), 32'd0);
    check("rst dmaReady", 32'(dmaReady), 32'd0);
    check("rst wbufCount", 32'(wbufCount), 32'd0);
    check("rst wbufOverflow", 32'(wbufOverflow), 32'd0);
    rst = 1'b0;
    tick();

    // CPU read with idle DMA, zero-wait memory.
    mem_lat = 0;
    c0 = cyc;
    cpuAddr = 32'h0000_1234; cpuRE = 1'b1;
    exp_acc(1'b0, 32'h0000_1234, 16'h0, c0 + 1);
    exp_rsp(1'b1, 16'hBEEF, 1'b1, c0 + 2);
    wait_cpu_ready("cpu_read");
    settle(6, "cpu_read");

    // Posted CPU write while a DMA read is stalled.
    mem_lat = 3;
    c0 = cyc;
    dmaAddr = 32'h40; dmaRE = 1'b1;
    exp_acc(1'b0, 32'h40, 16'h0, c0 + 1);
    exp_rsp(1'b0, 16'hAC9B, 1'b1, c0 + 5);
    exp_acc(1'b1, 32'h10, 16'hAAAA, c0 + 7);
    tick();
    cpuAddr = 32'h10; cpuWrite = 16'hAAAA; cpuWE = 1'b1;
    tick();
    cpuWE = 1'b0;
    check("posted wbufCount", 32'(wbufCount), 32'd1);
    wait_dma_ready("posted dma");
    settle(15, "posted");
    check("posted drained count", 32'(wbufCount), 32'd0);
    check("posted overflow", 32'(wbufOverflow), 32'd0);

    // Read-after-write ordering through the buffer.
    mem_lat = 0;
    c0 = cyc;
    cpuAddr = 32'h20; cpuWrite = 16'h5555; cpuWE = 1'b1;
    exp_acc(1'b1, 32'h20, 16'h5555, c0 + 2);
    exp_acc(1'b0, 32'h20, 16'h0, c0 + 5);
    exp_rsp(1'b1, 16'hACFB, 1'b1, c0 + 6);
    tick();
    cpuWE = 1'b0; cpuRE = 1'b1;
    wait_cpu_ready("raw");
    settle(6, "raw");

    // Round-robin with both masters requesting continuously.
    do_reset();
    c0 = cyc;
    cpuAddr = 32'h80; cpuRE = 1'b1;
    dmaAddr = 32'h90; dmaRE = 1'b1;
    exp_acc(1'b0, 32'h80, 16'h0, c0 + 1);
    exp_acc(1'b0, 32'h90, 16'h0, c0 + 4);
    exp_acc(1'b0, 32'h80, 16'h0, c0 + 7);
    exp_acc(1'b0, 32'h90, 16'h0, c0 + 10);
    exp_rsp(1'b1, 16'hAC5B, 1'b1, c0 + 2);
    exp_rsp(1'b0, 16'hAC4B, 1'b1, c0 + 5);
    exp_rsp(1'b1, 16'hAC5B, 1'b1, c0 + 8);
    exp_rsp(1'b0, 16'hAC4B, 1'b1, c0 + 11);
    repeat (11) tick();
    cpuRE = 1'b0; dmaRE = 1'b0;
    settle(6, "round_robin");

    // Overflow: DMA write holds the port while three CPU writes arrive.
    do_reset();
    mem_lat = 8;
    c0 = cyc;
    dmaAddr = 32'h300; dmaWrite = 16'h1111; dmaWE = 1'b1;
    exp_acc(1'b1, 32'h300, 16'h1111, c0 + 1);
    exp_rsp(1'b0, 16'h0, 1'b0, c0 + 10);
    exp_acc(1'b1, 32'h100, 16'h0A01, -1);
    exp_acc(1'b1, 32'h101, 16'h0A02, -1);
    tick();
    cpuWE = 1'b1; cpuAddr = 32'h100; cpuWrite = 16'h0A01;
    tick();
    cpuAddr = 32'h101; cpuWrite = 16'h0A02;
    tick();
    cpuAddr = 32'h102; cpuWrite = 16'h0A03;
    tick();
    cpuWE = 1'b0;
    check("ovf wbufCount", 32'(wbufCount), 32'd2);
    check("ovf wbufOverflow", 32'(wbufOverflow), 32'd1);
    wait_dma_ready("ovf dma");
    settle(60, "overflow");
    check("ovf sticky", 32'(wbufOverflow), 32'd1);
    check("ovf drained count", 32'(wbufCount), 32'd0);

    // Reset while a CPU read is in flight with a write queued.
    mem_lat = 20;
    c0 = cyc;
    cpuAddr = 32'h200; cpuRE = 1'b1;
    exp_acc(1'b0, 32'h200, 16'h0, c0 + 1);
    tick();
    cpuAddr = 32'h210; cpuWrite = 16'h7777; cpuWE = 1'b1;
    tick();
    cpuWE = 1'b0;
    check("midbusy pre memRE", 32'(memRE), 32'd1);
    check("midbusy pre count", 32'(wbufCount), 32'd1);
    rst = 1'b1; cpuRE = 1'b0;
    tick();
    check("midbusy memRE", 32'(memRE), 32'd0);
    check("midbusy memWE", 32'(memWE), 32'd0);
    check("midbusy wbufCount", 32'(wbufCount), 32'd0);
    check("midbusy wbufOverflow", 32'(wbufOverflow), 32'd0);
    check("midbusy cpuReady", 32'(cpuReady), 32'd0);
    rst = 1'b0;
    mem_lat = 0;
    settle(20, "midbusy");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
